// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback / register-file block.
package wb_pkg;

    localparam int WB_XLEN = 64;

    localparam logic [7:0] OPC_MUL   = 8'hF7;
    localparam logic [7:0] OPC_PUSH  = 8'hFF;
    localparam logic [7:0] OPC_STORE = 8'h89;
    localparam logic [7:0] OPC_LOAD  = 8'h8B;

    typedef struct packed {
        logic [WB_XLEN-1:0] alu_result;
        logic [WB_XLEN-1:0] alu_ext_result;
        logic [7:0]         ctl_opcode;
        logic [7:0]         ctl_regByte;
        logic [7:0]         ctl_rmByte;
        logic               sim_end;
    } ex_wb_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_STORE,
        ST_HALT
    } wb_state_t;

endpackage

// File: rtl/mod_writeback_rf_if.sv
// EX/WB packet handshake between execute/memory and the writeback block.
interface mod_writeback_rf_if;
    import wb_pkg::*;

    logic   wb_valid;
    logic   wb_ready;
    ex_wb_t exwb;

    modport master (output wb_valid, output exwb, input wb_ready);
    modport slave  (input wb_valid, input exwb, output wb_ready);

endinterface

// File: rtl/wb_regfile.sv
// Architectural register array: two write ports, two read ports that bypass
// same-cycle writes, plus a dedicated stack-pointer tap for PUSH.
module wb_regfile #(
    parameter int XLEN    = 64,
    parameter int NREGS   = 16,
    parameter int RIDX_W  = 4,
    parameter int RSP_IDX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [RIDX_W-1:0] widx0,
    input  logic [XLEN-1:0]   wdata0,
    input  logic              we1,
    input  logic [RIDX_W-1:0] widx1,
    input  logic [XLEN-1:0]   wdata1,
    input  logic [RIDX_W-1:0] ridx_a,
    input  logic [RIDX_W-1:0] ridx_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    output logic [XLEN-1:0]   rsp_data
);

    localparam logic [RIDX_W:0] NREGS_L = (RIDX_W+1)'(NREGS);

    logic [XLEN-1:0] mem [NREGS];

    function automatic logic in_range(input logic [RIDX_W-1:0] idx);
        return {1'b0, idx} < NREGS_L;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            if (we0) mem[widx0] <= wdata0;
            if (we1) mem[widx1] <= wdata1;
        end
    end

    // Callers gate we0/we1 on range, so a matching index is always valid.
    always_comb begin
        rdata_a = '0;
        if (in_range(ridx_a)) rdata_a = mem[ridx_a];
        if (we0 && widx0 == ridx_a) rdata_a = wdata0;
        if (we1 && widx1 == ridx_a) rdata_a = wdata1;
    end

    always_comb begin
        rdata_b = '0;
        if (in_range(ridx_b)) rdata_b = mem[ridx_b];
        if (we0 && widx0 == ridx_b) rdata_b = wdata0;
        if (we1 && widx1 == ridx_b) rdata_b = wdata1;
    end

    assign rsp_data = mem[RSP_IDX];

endmodule

// File: rtl/mod_writeback_rf.sv
// Clocked writeback stage: register file, dependency scoreboard, store wait
// and end-of-simulation halt.
//
// state         | meaning
// ST_IDLE       | ready for a packet
// ST_WAIT_STORE | accepted store waiting for store_done
// ST_HALT       | sim_end retired; only reset leaves
module mod_writeback_rf
    import wb_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int NREGS    = 16,
    parameter int RIDX_W   = 4,
    parameter int RSP_IDX  = 4,
    parameter int PUSH_DEC = 8
) (
    input  logic                clk,
    input  logic                reset,
    mod_writeback_rf_if.slave   wb,
    input  logic                store_done,
    input  logic                iss_valid,
    input  logic [NREGS-1:0]    iss_mask,
    input  logic [RIDX_W-1:0]   rd_idx_a,
    input  logic [RIDX_W-1:0]   rd_idx_b,
    output logic [XLEN-1:0]     rd_data_a,
    output logic [XLEN-1:0]     rd_data_b,
    output logic [NREGS-1:0]    busy,
    output logic                store_wb_flag,
    output logic                sim_done
);

    localparam logic [7:0] NREGS_B = 8'(NREGS);

    wb_state_t         state;
    ex_wb_t            pkt;
    logic              accept;
    logic              we0, we1;
    logic [RIDX_W-1:0] widx0, widx1;
    logic [XLEN-1:0]   wdata0, wdata1;
    logic [XLEN-1:0]   rsp_data;
    logic [NREGS-1:0]  clear_mask;
    logic [7:0]        tgt;

    assign pkt         = wb.exwb;
    assign wb.wb_ready = (state == ST_IDLE);
    assign accept      = wb.wb_valid & wb.wb_ready;

    always_comb begin
        we0        = 1'b0;
        we1        = 1'b0;
        widx0      = '0;
        widx1      = '0;
        wdata0     = '0;
        wdata1     = '0;
        clear_mask = '0;
        tgt        = pkt.ctl_rmByte;
        if (accept) begin
            case (pkt.ctl_opcode)
                OPC_MUL: begin
                    we0           = 1'b1;
                    widx0         = RIDX_W'(0);
                    wdata0        = pkt.alu_result[XLEN-1:0];
                    we1           = 1'b1;
                    widx1         = RIDX_W'(2);
                    wdata1        = pkt.alu_ext_result[XLEN-1:0];
                    clear_mask[0] = 1'b1;
                    clear_mask[2] = 1'b1;
                end
                OPC_PUSH: begin
                    we0                 = 1'b1;
                    widx0               = RIDX_W'(RSP_IDX);
                    wdata0              = rsp_data - XLEN'(PUSH_DEC);
                    clear_mask[RSP_IDX] = 1'b1;
                end
                OPC_STORE: ;
                default: begin
                    if (pkt.ctl_opcode == OPC_LOAD) tgt = pkt.ctl_regByte;
                    // Out-of-range targets are dropped rather than aliased.
                    if (tgt < NREGS_B) begin
                        we0                        = 1'b1;
                        widx0                      = tgt[RIDX_W-1:0];
                        wdata0                     = pkt.alu_result[XLEN-1:0];
                        clear_mask[tgt[RIDX_W-1:0]] = 1'b1;
                    end
                end
            endcase
        end
    end

    wb_regfile #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .RIDX_W  (RIDX_W),
        .RSP_IDX (RSP_IDX)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we0      (we0),
        .widx0    (widx0),
        .wdata0   (wdata0),
        .we1      (we1),
        .widx1    (widx1),
        .wdata1   (wdata1),
        .ridx_a   (rd_idx_a),
        .ridx_b   (rd_idx_b),
        .rdata_a  (rd_data_a),
        .rdata_b  (rd_data_b),
        .rsp_data (rsp_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= '0;
            store_wb_flag <= 1'b0;
            sim_done      <= 1'b0;
        end else begin
            store_wb_flag <= 1'b0;
            // Set is ORed in after the clear so a same-cycle issue wins.
            busy <= (busy & ~clear_mask) | (iss_valid ? iss_mask : '0);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (pkt.ctl_opcode == OPC_PUSH ||
                            (pkt.ctl_opcode == OPC_STORE && store_done))
                            store_wb_flag <= 1'b1;
                        if (pkt.sim_end) begin
                            state    <= ST_HALT;
                            sim_done <= 1'b1;
                        end else if (pkt.ctl_opcode == OPC_STORE && !store_done) begin
                            state <= ST_WAIT_STORE;
                        end
                    end
                end
                ST_WAIT_STORE: begin
                    if (store_done) begin
                        store_wb_flag <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_writeback_rf.sv
// Scoreboarded bench for mod_writeback_rf: expected register contents are
// queued as packets are sent and compared through read port A afterwards.
module tb_mod_writeback_rf;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        store_done;
    logic        iss_valid;
    logic [15:0] iss_mask;
    logic [3:0]  rd_idx_a, rd_idx_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [15:0] busy;
    logic        store_wb_flag;
    logic        sim_done;

    mod_writeback_rf_if wb_if ();

    mod_writeback_rf dut (
        .clk           (clk),
        .reset         (reset),
        .wb            (wb_if),
        .store_done    (store_done),
        .iss_valid     (iss_valid),
        .iss_mask      (iss_mask),
        .rd_idx_a      (rd_idx_a),
        .rd_idx_b      (rd_idx_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .busy          (busy),
        .store_wb_flag (store_wb_flag),
        .sim_done      (sim_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          idx;
        logic [63:0] val;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] m_reg[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_expect(input string tag, input int idx, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb_q.push_back(e);
        m_reg[idx] = val;
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_idx_a = 4'(e.idx);
            #1;
            check(e.tag, rd_data_a, e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
    endtask

    // Drives one packet (held until the caller's next tick) and queues its effect.
    task automatic send(input logic [7:0] op, input logic [7:0] rb, input logic [7:0] rm,
                        input logic [63:0] res, input logic [63:0] ext, input logic se);
        wb_if.exwb.ctl_opcode     = op;
        wb_if.exwb.ctl_regByte    = rb;
        wb_if.exwb.ctl_rmByte     = rm;
        wb_if.exwb.alu_result     = res;
        wb_if.exwb.alu_ext_result = ext;
        wb_if.exwb.sim_end        = se;
        wb_if.wb_valid            = 1'b1;
        #1;
        check("ready_at_send", 64'(wb_if.wb_ready), 64'd1);
        case (op)
            8'hF7: begin
                sb_expect("mul_r0", 0, res);
                sb_expect("mul_r2", 2, ext);
            end
            8'hFF: sb_expect("push_rsp", 4, m_reg[4] - 64'd8);
            8'h89: ;
            8'h8B: if (rb < 8'd16) sb_expect("load_reg", int'(rb), res);
            default: if (rm < 8'd16) sb_expect("gen_reg", int'(rm), res);
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        store_done = 1'b0;
        iss_valid  = 1'b0;
        iss_mask   = '0;
        rd_idx_a   = '0;
        rd_idx_b   = '0;
        wb_if.wb_valid = 1'b0;
        wb_if.exwb     = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", 64'(wb_if.wb_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sim_done", 64'(sim_done), 64'd0);
        check("rst_flag", 64'(store_wb_flag), 64'd0);
        rd_idx_a = 4'd3;
        #1;
        check("rst_reg3", rd_data_a, 64'd0);

        // Mark reg3 busy, then retire a generic write to it.
        iss_valid = 1'b1;
        iss_mask  = 16'h0008;
        tick();
        iss_valid = 1'b0;
        iss_mask  = '0;
        check("busy_set3", 64'(busy), 64'h0008);
        send(8'h01, 8'd0, 8'd3, 64'hDEAD, 64'd0, 1'b0);
        rd_idx_a = 4'd3;
        #1;
        check("gen_bypass_a", rd_data_a, 64'hDEAD);
        tick();
        wb_if.wb_valid = 1'b0;
        check("busy_clr3", 64'(busy), 64'd0);
        sb_drain();

        send(8'hF7, 8'd0, 8'd0, 64'd5, 64'd7, 1'b0);
        rd_idx_a = 4'd0;
        rd_idx_b = 4'd2;
        #1;
        check("mul_bypass_a", rd_data_a, 64'd5);
        check("mul_bypass_b", rd_data_b, 64'd7);
        tick();
        wb_if.wb_valid = 1'b0;
        sb_drain();

        send(8'hFF, 8'd0, 8'd0, 64'h1111, 64'd0, 1'b0);
        rd_idx_a = 4'd4;
        #1;
        check("push_bypass", rd_data_a, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        wb_if.wb_valid = 1'b0;
        check("push_flag_hi", 64'(store_wb_flag), 64'd1);
        sb_drain();
        tick();
        check("push_flag_lo", 64'(store_wb_flag), 64'd0);

        send(8'hFF, 8'd0, 8'd0, 64'd0, 64'd0, 1'b0);
        tick();
        wb_if.wb_valid = 1'b0;
        sb_drain();
        check("push2_model", m_reg[4], 64'hFFFF_FFFF_FFFF_FFF0);

        // Store that waits three cycles for store_done.
        send(8'h89, 8'd0, 8'd0, 64'hBEEF, 64'd0, 1'b0);
        tick();
        wb_if.wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("store_wait_ready", 64'(wb_if.wb_ready), 64'd0);
            check("store_wait_flag", 64'(store_wb_flag), 64'd0);
            if (i < 2) tick();
        end
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        check("store_done_flag", 64'(store_wb_flag), 64'd1);
        check("store_done_ready", 64'(wb_if.wb_ready), 64'd1);
        tick();
        check("store_flag_once", 64'(store_wb_flag), 64'd0);
        sb_expect("store_keep_r3", 3, m_reg[3]);
        sb_expect("store_keep_r0", 0, m_reg[0]);
        sb_expect("store_keep_r4", 4, m_reg[4]);
        sb_drain();

        // Store already committed in the accept cycle.
        store_done = 1'b1;
        send(8'h89, 8'd0, 8'd0, 64'd0, 64'd0, 1'b0);
        tick();
        wb_if.wb_valid = 1'b0;
        store_done = 1'b0;
        check("store_imm_flag", 64'(store_wb_flag), 64'd1);
        check("store_imm_ready", 64'(wb_if.wb_ready), 64'd1);
        tick();
        check("store_imm_once", 64'(store_wb_flag), 64'd0);

        // Out-of-range target (19) is dropped, must not alias onto reg3.
        send(8'h01, 8'd0, 8'd19, 64'hBAD0, 64'd0, 1'b0);
        tick();
        wb_if.wb_valid = 1'b0;
        sb_expect("oor_keep_r3", 3, m_reg[3]);
        sb_drain();

        // Reset in the second wait cycle abandons the store.
        send(8'h89, 8'd0, 8'd0, 64'd0, 64'd0, 1'b0);
        tick();
        wb_if.wb_valid = 1'b0;
        check("store_rst_wait", 64'(wb_if.wb_ready), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        store_done = 1'b1;
        model_reset();
        check("store_rst_flag", 64'(store_wb_flag), 64'd0);
        tick();
        store_done = 1'b0;
        check("store_rst_noflag", 64'(store_wb_flag), 64'd0);
        check("store_rst_ready", 64'(wb_if.wb_ready), 64'd1);
        sb_expect("rst_clr_r3", 3, 64'd0);
        sb_expect("rst_clr_r4", 4, 64'd0);
        sb_drain();

        // LOAD and issue to the same register: set wins.
        send(8'h8B, 8'd5, 8'd1, 64'h1234, 64'd0, 1'b0);
        iss_valid = 1'b1;
        iss_mask  = 16'h0020;
        rd_idx_b  = 4'd5;
        #1;
        check("load_bypass_b", rd_data_b, 64'h1234);
        tick();
        wb_if.wb_valid = 1'b0;
        iss_valid = 1'b0;
        iss_mask  = '0;
        check("busy_set_wins", 64'(busy), 64'h0020);
        sb_drain();

        // sim_end packet still commits its write, then the block halts.
        send(8'h01, 8'd0, 8'd1, 64'd9, 64'd0, 1'b1);
        tick();
        wb_if.wb_valid = 1'b0;
        check("halt_sim_done", 64'(sim_done), 64'd1);
        check("halt_ready", 64'(wb_if.wb_ready), 64'd0);
        sb_drain();
        wb_if.exwb.sim_end    = 1'b0;
        wb_if.exwb.alu_result = 64'h77;
        wb_if.wb_valid        = 1'b1;
        tick();
        tick();
        wb_if.wb_valid = 1'b0;
        check("halt_ready_hold", 64'(wb_if.wb_ready), 64'd0);
        check("halt_sticky", 64'(sim_done), 64'd1);
        sb_expect("halt_ignore_r1", 1, 64'd9);
        sb_drain();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("exit_sim_done", 64'(sim_done), 64'd0);
        check("exit_ready", 64'(wb_if.wb_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
